mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the EX/MEM register. It drives the data-memory bus from the EX/MEM outputs, waits out multi-cycle memory latency with a small handshake FSM, and stalls the front of the pipeline while waiting. It owns the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- MAX_WAIT, 15: wait cycles without `dmem_ack` before a bus timeout is declared. Legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- alu_result_in  in  32  EX/MEM ALU result; also the memory address
- store_data_in  in  32  EX/MEM register read data; the store data
- pc_after_add_in  in  32  EX/MEM PC+4
- write_address_in  in  5  EX/MEM destination register
- we_in  in  3  write-back control: [2] reg_write, [1:0] wb select (00 ALU, 01 mem, 10 PC+4)
- m_in  in  2  memory control: [1] mem_read, [0] mem_write
- dmem_req  out  1  bus request
- dmem_wr  out  1  1 = write, 0 = read
- dmem_addr  out  32  byte address
- dmem_wdata  out  32  write data
- dmem_rdata  in  32  read data, valid with `dmem_ack`
- dmem_ack  in  1  access complete
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- alu_result_out, mem_data_out, pc_after_add_out  out  32 each  MEM/WB fields
- write_address_out  out  5  MEM/WB destination register
- we_out  out  3  MEM/WB write-back control
- mem_err  out  1  sticky bus-error flag

## Operation
- Access condition: `access = (m_in == 01 or m_in == 10)`.
  - `m_in == 00` is not an access.
  - `m_in == 11` is illegal. It performs no access, sets `mem_err`, and passes through with `we_out[2]` forced to 0.
- Bus signals are combinational:
  - `dmem_req = access` in IDLE, and 1 in WAIT.
  - `dmem_wr = m_in[0]`.
  - `dmem_addr = alu_result_in`.
  - `dmem_wdata = store_data_in`.
- `stall_out = dmem_req & ~dmem_ack & ~timeout`.
- FSM, 2 states, 8-bit wait counter `cnt`:
  - IDLE, no access: MEM/WB loads the inputs. `mem_data_out` loads 0.
  - IDLE, access with `dmem_ack` = 1 (zero-wait): MEM/WB loads the inputs. `mem_data_out` loads `dmem_rdata` for a read, or 0 for a write. Stay IDLE.
  - IDLE, access with `dmem_ack` = 0: go to WAIT with `cnt` = 1. MEM/WB loads a bubble.
  - WAIT with `dmem_ack` = 1: MEM/WB loads the inputs and read data as above. Go to IDLE, `cnt` = 0.
  - WAIT, no ack, `cnt` < MAX_WAIT: `cnt` increments. MEM/WB loads a bubble.
  - WAIT, no ack, `cnt` == MAX_WAIT (this is `timeout`): set `mem_err`. MEM/WB loads the inputs with `mem_data_out` = 0 and `we_out[2]` = 0. Go to IDLE, `cnt` = 0.
- Bubble definition: `we_out` = 000; all other MEM/WB fields hold their value. A bubble never repeats or loses a register write.
- `dmem_ack` outside a request is ignored.
- Upstream inputs are stable throughout WAIT because `stall_out` freezes EX/MEM.
- `mem_err` clears only on reset.

## Timing
- Reset, asynchronous: state IDLE, `cnt` = 0, `mem_err` = 0, and every MEM/WB output is 0.
- While `rst` is high, `dmem_req` and `stall_out` are forced to 0.
- Reset during WAIT abandons the access immediately.
- Latency:
  - Non-memory instruction or zero-wait access: 1 cycle, input to MEM/WB output.
  - Access acked after N wait cycles: N+1 cycles. `stall_out` is high for exactly N cycles.
  - Timeout: `stall_out` is high for MAX_WAIT cycles. Outputs update at the edge ending cycle MAX_WAIT+1.
- `stall_out` drops in the same cycle `dmem_ack` rises, so the next instruction enters on the following edge.
- Ack arriving on the timeout cycle: the ack wins, and `mem_err` is not set.
- Back-to-back accesses: the second request starts the cycle after the first completes. There is no idle gap.

## Test plan
- Reset mid-WAIT: drive `rst`=1 asynchronously between edges. All outputs go to 0 immediately, `dmem_req` = 0, and the FSM is in IDLE after release.
- ALU op: `alu_result_in` = 0x0000_0010, `we_in` = 100, `m_in` = 00, write_address 5 → next edge: `alu_result_out` = 0x10, `we_out` = 100, `mem_data_out` = 0, `stall_out` never high.
- Zero-wait load: `m_in` = 10, addr 0x40, `dmem_ack` = 1 in the same cycle, `dmem_rdata` = 0xDEAD_BEEF → `stall_out` stays 0, `mem_data_out` = 0xDEADBEEF after 1 edge.
- 3-wait store: `m_in` = 01, `store_data_in` = 0x1234_5678, ack on the 4th cycle → `dmem_wr` = 1 and `dmem_wdata` stable for 4 cycles, `stall_out` high for 3 cycles, `we_out` = 000 for 3 edges, then the inputs are loaded.
- Timeout with MAX_WAIT = 4: load with no ack → `stall_out` high for 4 cycles. Then `mem_err` = 1, `we_out[2]` = 0, `mem_data_out` = 0; `mem_err` stays 1 through later good accesses.
- Illegal control: `m_in` = 11 with `we_in` = 101 → `dmem_req` = 0, `mem_err` = 1, `we_out` = 001, no stall.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Bundles the EX/MEM inputs, data-memory bus and MEM/WB outputs of the memory-access stage.
// Latency: none, this is only wiring.
// Backpressure: stall_out travels back to the front of the pipe through this bundle.
interface mem_access_stage_if;

   // EX/MEM register outputs feeding the stage
   logic [31:0] alu_result_in;
   logic [31:0] store_data_in;
   logic [31:0] pc_after_add_in;
   logic [4:0]  write_address_in;
   logic [2:0]  we_in;
   logic [1:0]  m_in;

   // Data-memory bus
   logic        dmem_req;
   logic        dmem_wr;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   // Pipeline control back to the front end
   logic        stall_out;

   // MEM/WB register fields
   logic [31:0] alu_result_out;
   logic [31:0] mem_data_out;
   logic [31:0] pc_after_add_out;
   logic [4:0]  write_address_out;
   logic [2:0]  we_out;
   logic        mem_err;

   // The stage itself: drives the memory bus and the MEM/WB fields
   modport master (
      input  alu_result_in, store_data_in, pc_after_add_in, write_address_in,
      input  we_in, m_in, dmem_rdata, dmem_ack,
      output dmem_req, dmem_wr, dmem_addr, dmem_wdata, stall_out,
      output alu_result_out, mem_data_out, pc_after_add_out, write_address_out,
      output we_out, mem_err
   );

   // The surroundings: EX/MEM, data memory and write-back
   modport slave (
      output alu_result_in, store_data_in, pc_after_add_in, write_address_in,
      output we_in, m_in, dmem_rdata, dmem_ack,
      input  dmem_req, dmem_wr, dmem_addr, dmem_wdata, stall_out,
      input  alu_result_out, mem_data_out, pc_after_add_out, write_address_out,
      input  we_out, mem_err
   );

endinterface

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: drives the data bus from EX/MEM and owns the MEM/WB register.
// Latency: 1 cycle for non-memory or zero-wait accesses, N+1 cycles for an access acked after N waits.
// Backpressure: stall_out holds the front of the pipe while a request waits for dmem_ack (bounded by MAX_WAIT).
module mem_access_stage #(
   parameter int MAX_WAIT = 15
) (
   input  logic               clk,
   input  logic               rst,
   mem_access_stage_if.master bus
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_cnt;
   logic        r_mem_err;

   logic [31:0] r_alu_result;
   logic [31:0] r_mem_data;
   logic [31:0] r_pc_after_add;
   logic [4:0]  r_write_address;
   logic [2:0]  r_we;

   logic        w_access;
   logic        w_illegal;
   logic        w_is_read;
   logic        w_timeout;
   logic        w_req;
   logic        w_done;
   logic [31:0] w_mem_data_nxt;
   logic [2:0]  w_we_nxt;

   // Decode of the memory control field; 11 is an illegal encoding and never touches the bus
   assign w_access  = (bus.m_in == 2'b01) || (bus.m_in == 2'b10);
   assign w_illegal = (bus.m_in == 2'b11);
   assign w_is_read = (bus.m_in == 2'b10);

   // The wait budget is spent only when no ack shows up on the last allowed cycle; a late ack still wins
   assign w_timeout = (r_state == ST_WAIT) && !bus.dmem_ack && (r_cnt == LP_MAX_WAIT);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: enter WAIT on an unacked request, leave on ack or timeout
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_access && !bus.dmem_ack) begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.dmem_ack || w_timeout) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: bus request and whether MEM/WB takes the instruction this cycle or a bubble
   always_comb begin
      w_req  = 1'b0;
      w_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req  = w_access;
            w_done = !w_access || bus.dmem_ack;
         end
         ST_WAIT: begin
            w_req  = 1'b1;
            w_done = bus.dmem_ack || w_timeout;
         end
         default: begin
            w_req  = 1'b0;
            w_done = 1'b0;
         end
      endcase
      // Reset kills any outstanding request at once, not at the next edge
      if (rst) begin
         w_req = 1'b0;
      end
   end

   // Read data is captured only on an acked read; stores, non-accesses and timeouts write back zero
   assign w_mem_data_nxt = (w_access && w_is_read && bus.dmem_ack) ? bus.dmem_rdata : 32'd0;

   // Failed instructions (illegal control or timeout) still flow through, but never write the register file
   assign w_we_nxt = {bus.we_in[2] & ~w_illegal & ~w_timeout, bus.we_in[1:0]};

   assign bus.dmem_req   = w_req;
   assign bus.dmem_wr    = bus.m_in[0];
   assign bus.dmem_addr  = bus.alu_result_in;
   assign bus.dmem_wdata = bus.store_data_in;
   assign bus.stall_out  = w_req & ~bus.dmem_ack & ~w_timeout;

   // Wait counter: 1 on the first wait cycle, cleared whenever the access finishes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 8'd0;
      end else if (r_state == ST_IDLE) begin
         r_cnt <= (w_access && !bus.dmem_ack) ? 8'd1 : 8'd0;
      end else if (bus.dmem_ack || w_timeout) begin
         r_cnt <= 8'd0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // Sticky bus-error flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_err <= 1'b0;
      end else if ((w_illegal && (r_state == ST_IDLE)) || w_timeout) begin
         r_mem_err <= 1'b1;
      end
   end

   // MEM/WB register: load the instruction when it completes, otherwise insert a bubble (only we is cleared)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_result    <= 32'd0;
         r_mem_data      <= 32'd0;
         r_pc_after_add  <= 32'd0;
         r_write_address <= 5'd0;
         r_we            <= 3'd0;
      end else if (w_done) begin
         r_alu_result    <= bus.alu_result_in;
         r_mem_data      <= w_mem_data_nxt;
         r_pc_after_add  <= bus.pc_after_add_in;
         r_write_address <= bus.write_address_in;
         r_we            <= w_we_nxt;
      end else begin
         r_we            <= 3'd0;
      end
   end

   assign bus.alu_result_out    = r_alu_result;
   assign bus.mem_data_out      = r_mem_data;
   assign bus.pc_after_add_out  = r_pc_after_add;
   assign bus.write_address_out = r_write_address;
   assign bus.we_out            = r_we;
   assign bus.mem_err           = r_mem_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against an instruction-level model.
// Latency: each instruction is modelled as a whole: ack latency in, stall cycles and MEM/WB contents out.
// Backpressure: the bench keeps EX/MEM inputs frozen for exactly the cycles the model says are stalled.
module tb_mem_access_stage;

   localparam int MAX_WAIT = 4;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] md;
      logic [31:0] pc;
      logic [4:0]  wa;
      logic [2:0]  we;
   } mw_t;

   logic clk;
   logic rst;

   mem_access_stage_if u_if ();

   mem_access_stage #(
      .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   int n_pass = 0;
   int n_tot  = 0;
   int n_stall = 0;
   bit chk_en = 0;

   // Model state: expected MEM/WB contents, sticky error, and expected combinational bus outputs
   mw_t         exp_mw;
   logic        exp_err;
   logic        exp_req;
   logic        exp_stall;
   logic        exp_wr;
   logic [31:0] exp_addr;
   logic [31:0] exp_wdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Single compare process: every falling edge the DUT must match the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("dmem_req",          32'(u_if.dmem_req),          32'(exp_req));
         chk("stall_out",         32'(u_if.stall_out),         32'(exp_stall));
         chk("dmem_wr",           32'(u_if.dmem_wr),           32'(exp_wr));
         chk("dmem_addr",         u_if.dmem_addr,              exp_addr);
         chk("dmem_wdata",        u_if.dmem_wdata,             exp_wdata);
         chk("alu_result_out",    u_if.alu_result_out,         exp_mw.alu);
         chk("mem_data_out",      u_if.mem_data_out,           exp_mw.md);
         chk("pc_after_add_out",  u_if.pc_after_add_out,       exp_mw.pc);
         chk("write_address_out", 32'(u_if.write_address_out), 32'(exp_mw.wa));
         chk("we_out",            32'(u_if.we_out),            32'(exp_mw.we));
         chk("mem_err",           32'(u_if.mem_err),           32'(exp_err));
         if (u_if.stall_out) n_stall++;
      end
   end

   // One instruction presented to the stage. lat = cycle index of the ack; lat > MAX_WAIT means never acked.
   // Called at posedge+1; returns at posedge+1 after the edge that loads the instruction into MEM/WB.
   task automatic run_instr(input logic [1:0] m, input logic [2:0] we, input logic [31:0] alu,
                            input logic [31:0] sd, input logic [31:0] pc, input logic [4:0] wa,
                            input int lat, input logic [31:0] rd);
      bit          acc;
      bit          ill;
      bit          to;
      int          ncyc;
      logic [31:0] rd_ack;
      acc  = (m == 2'b01) || (m == 2'b10);
      ill  = (m == 2'b11);
      to   = acc && (lat > MAX_WAIT);
      ncyc = !acc ? 1 : (to ? MAX_WAIT + 1 : lat + 1);
      rd_ack = 32'd0;
      u_if.m_in             = m;
      u_if.we_in            = we;
      u_if.alu_result_in    = alu;
      u_if.store_data_in    = sd;
      u_if.pc_after_add_in  = pc;
      u_if.write_address_in = wa;
      exp_req   = acc;
      exp_wr    = m[0];
      exp_addr  = alu;
      exp_wdata = sd;
      for (int k = 0; k < ncyc; k++) begin
         if (acc) begin
            u_if.dmem_ack = (k == lat);
         end else begin
            u_if.dmem_ack = 1'($urandom_range(0, 1));
         end
         u_if.dmem_rdata = (acc && k == lat) ? rd : $urandom;
         if (acc && k == lat) rd_ack = rd;
         exp_stall = acc && (k < ncyc - 1);
         @(posedge clk);
         #1;
         if (k < ncyc - 1) begin
            exp_mw.we = 3'b000;
         end else begin
            exp_mw.alu = alu;
            exp_mw.pc  = pc;
            exp_mw.wa  = wa;
            exp_mw.md  = (m == 2'b10 && !to) ? rd_ack : 32'd0;
            exp_mw.we  = {we[2] & ~ill & ~to, we[1:0]};
            if (ill || to) exp_err = 1'b1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      // Present a load during reset: the request must stay masked
      u_if.m_in             = 2'b10;
      u_if.we_in            = 3'b101;
      u_if.alu_result_in    = 32'h0000_0abc;
      u_if.store_data_in    = 32'h0;
      u_if.pc_after_add_in  = 32'h0;
      u_if.write_address_in = 5'd0;
      u_if.dmem_rdata       = 32'h0;
      u_if.dmem_ack         = 1'b0;
      exp_mw    = '0;
      exp_err   = 1'b0;
      exp_req   = 1'b0;
      exp_stall = 1'b0;
      exp_wr    = 1'b0;
      exp_addr  = 32'h0000_0abc;
      exp_wdata = 32'h0;
      #1 rst = 1'b1;
      #2;
      chk("reset_req",    32'(u_if.dmem_req), 32'd0);
      chk("reset_we_out", 32'(u_if.we_out),   32'd0);
      chk("reset_alu",    u_if.alu_result_out, 32'd0);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // ALU op: no memory access, one cycle through
      n_stall = 0;
      run_instr(2'b00, 3'b100, 32'h0000_0010, 32'h5555_aaaa, 32'h0000_0104, 5'd5, 0, 32'h0);
      chk("alu_lit_result", u_if.alu_result_out, 32'h0000_0010);
      chk("alu_lit_we",     32'(u_if.we_out),    32'h4);
      chk("alu_lit_md",     u_if.mem_data_out,   32'h0);
      chk("alu_lit_wa",     32'(u_if.write_address_out), 32'd5);
      chk("alu_lit_stall",  32'(n_stall), 32'd0);

      // Zero-wait load
      n_stall = 0;
      run_instr(2'b10, 3'b101, 32'h0000_0040, 32'h0, 32'h0000_0108, 5'd6, 0, 32'hDEAD_BEEF);
      chk("zw_lit_md",    u_if.mem_data_out, 32'hDEAD_BEEF);
      chk("zw_lit_stall", 32'(n_stall), 32'd0);

      // Store acked on the 4th cycle: 3 stall cycles
      n_stall = 0;
      run_instr(2'b01, 3'b000, 32'h0000_0080, 32'h1234_5678, 32'h0000_010c, 5'd0, 3, 32'h0);
      chk("st3_lit_stall", 32'(n_stall), 32'd3);
      chk("st3_lit_alu",   u_if.alu_result_out, 32'h0000_0080);

      // Illegal control: no request, error set, register write suppressed
      n_stall = 0;
      run_instr(2'b11, 3'b101, 32'h0000_00c0, 32'h0, 32'h0000_0110, 5'd7, 0, 32'h0);
      chk("ill_lit_we",    32'(u_if.we_out),  32'h1);
      chk("ill_lit_err",   32'(u_if.mem_err), 32'd1);
      chk("ill_lit_stall", 32'(n_stall), 32'd0);

      // Reset in the middle of a wait: everything clears asynchronously
      u_if.m_in          = 2'b10;
      u_if.we_in         = 3'b101;
      u_if.alu_result_in = 32'h0000_0200;
      u_if.dmem_ack      = 1'b0;
      exp_req   = 1'b1;
      exp_stall = 1'b1;
      exp_wr    = 1'b0;
      exp_addr  = 32'h0000_0200;
      repeat (2) begin
         @(posedge clk);
         #1 exp_mw.we = 3'b000;
      end
      #2;
      rst       = 1'b1;
      exp_req   = 1'b0;
      exp_stall = 1'b0;
      exp_mw    = '0;
      exp_err   = 1'b0;
      #1;
      chk("midrst_req",   32'(u_if.dmem_req),  32'd0);
      chk("midrst_stall", 32'(u_if.stall_out), 32'd0);
      chk("midrst_alu",   u_if.alu_result_out, 32'd0);
      chk("midrst_pc",    u_if.pc_after_add_out, 32'd0);
      chk("midrst_err",   32'(u_if.mem_err),   32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Timeout: load never acked
      n_stall = 0;
      run_instr(2'b10, 3'b101, 32'h0000_0300, 32'h0, 32'h0000_0204, 5'd9, MAX_WAIT + 1, 32'h0);
      chk("to_lit_stall", 32'(n_stall), 32'd4);
      chk("to_lit_err",   32'(u_if.mem_err), 32'd1);
      chk("to_lit_we",    32'(u_if.we_out),  32'h1);
      chk("to_lit_md",    u_if.mem_data_out, 32'h0);

      // Ack exactly on the timeout cycle, after an error is already latched: ack wins, error stays
      run_instr(2'b10, 3'b101, 32'h0000_0304, 32'h0, 32'h0000_0208, 5'd10, MAX_WAIT, 32'hCAFE_F00D);
      chk("late_lit_md",  u_if.mem_data_out, 32'hCAFE_F00D);
      chk("late_lit_we",  32'(u_if.we_out),  32'h5);
      chk("late_lit_err", 32'(u_if.mem_err), 32'd1);

      // Randomized mix of ALU ops, loads, stores, illegal codes and ack latencies, back to back
      for (int i = 0; i < 200; i++) begin
         int          sel;
         int          lat;
         logic [1:0]  m;
         sel = $urandom_range(0, 7);
         if (sel <= 2)      m = 2'b00;
         else if (sel <= 4) m = 2'b10;
         else if (sel <= 6) m = 2'b01;
         else               m = 2'b11;
         lat = ($urandom_range(0, 9) < 4) ? 0 : $urandom_range(0, MAX_WAIT + 2);
         run_instr(m, 3'($urandom), $urandom, $urandom, $urandom, 5'($urandom), lat, $urandom);
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
